// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Shared definitions for the clock datapath: digit moduli, default button
//   conditioning parameters, the counter operation encoding and the BCD
//   split used by both the digit counters and the display driver.
// ---------------------------------------------------------------------------
package clock_pkg;

    localparam int SEC_MODULUS             = 60;
    localparam int MIN_MODULUS             = 60;
    localparam int HOUR_MODULUS            = 24;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    // Operation selected for the current edge, in priority order.
    typedef enum logic [2:0] {
        OP_IDLE = 3'd0,
        OP_LOAD = 3'd1,
        OP_KEEP = 3'd2,
        OP_UP   = 3'd3,
        OP_DOWN = 3'd4
    } count_op_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Splits a value in 0..99 into BCD tens and ones digits.
    function automatic bcd_t to_bcd(input logic [6:0] value);
        bcd_t result;
        result.tens = 4'(value / 7'd10);
        result.ones = 4'(value % 7'd10);
        return result;
    endfunction

endpackage : clock_pkg

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Turns a raw asynchronous pushbutton into a clean debounced level and a
//   single-cycle pulse on each debounced press.
//
//   Ports:
//     clk        in   system clock, rising edge
//     clear      in   asynchronous active-high reset
//     raw        in   raw pushbutton, active-high, asynchronous
//     level      out  debounced button level (0 = released)
//     rise_pulse out  one-cycle registered pulse on a debounced rise
//
//   After clear the conditioner is disarmed: a button that is already held
//   when clear drops produces no pulse. It re-arms once the synchronised
//   input has been seen low for DEBOUNCE_CYCLES consecutive real samples.
// ---------------------------------------------------------------------------
module button_conditioner
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("button_conditioner: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    // Fills with ones after clear; marks when sync_q holds sampled data
    // rather than its reset zeros.
    logic [SYNC_STAGES-1:0] fill_q;
    logic [CNT_W-1:0]       stable_cnt_q, stable_cnt_d;
    logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
    logic                   level_q, level_d;
    logic                   level_prev_q;
    logic                   armed_q, armed_d;
    logic                   rise_q, rise_d;
    logic                   sync_level;
    logic                   sample_valid;

    assign sync_level   = sync_q[SYNC_STAGES-1];
    assign sample_valid = fill_q[SYNC_STAGES-1];

    always_comb begin
        stable_cnt_d = '0;
        level_d      = level_q;
        low_cnt_d    = low_cnt_q;
        armed_d      = armed_q;
        rise_d       = level_q & ~level_prev_q & armed_q;

        // Count consecutive samples that disagree with the debounced level;
        // any sample that agrees restarts the count.
        if (sync_level != level_q) begin
            if (stable_cnt_q == CNT_LAST) begin
                level_d = sync_level;
            end else begin
                stable_cnt_d = stable_cnt_q + CNT_W'(1);
            end
        end

        if (!armed_q) begin
            if (sample_valid && !sync_level) begin
                if (low_cnt_q == CNT_LAST) begin
                    armed_d = 1'b1;
                end else begin
                    low_cnt_d = low_cnt_q + CNT_W'(1);
                end
            end else begin
                low_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync_q       <= '0;
            fill_q       <= '0;
            stable_cnt_q <= '0;
            low_cnt_q    <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], raw};
            fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            stable_cnt_q <= stable_cnt_d;
            low_cnt_q    <= low_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            armed_q      <= armed_d;
            rise_q       <= rise_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule : button_conditioner

// File: rtl/modn_counter.sv
// ---------------------------------------------------------------------------
// modn_counter
//   Modulo-MODULUS up/down digit counter with parallel load, hold, a
//   conditioned adjust pushbutton and registered carry/borrow pulses for
//   chaining seconds -> minutes -> hours.
//
//   Ports:
//     clk        in   system clock, rising edge
//     clear      in   asynchronous active-high reset
//     tick       in   one-cycle count-enable strobe
//     adjust     in   raw pushbutton; each debounced press steps once
//     keep       in   hold count; tick/adjust that cycle are dropped
//     down       in   0 = count up, 1 = count down
//     load       in   synchronous load of min(load_value, MODULUS-1)
//     load_value in   value for load
//     count      out  current count, 0..MODULUS-1
//     carry      out  registered pulse after a tick-caused up-wrap
//     borrow     out  registered pulse after a tick-caused down-wrap
//     adj_pulse  out  debounced adjust press pulse
//     tens, ones out  BCD digits of count (combinational)
// ---------------------------------------------------------------------------
module modn_counter
    import clock_pkg::*;
#(
    parameter int MODULUS         = 60,
    parameter int WIDTH           = 6,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             tick,
    input  logic             adjust,
    input  logic             keep,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             adj_pulse,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("modn_counter: MODULUS must be in 2..100");
    end
    if (MODULUS > 2 ** WIDTH) begin : g_bad_width
        $error("modn_counter: MODULUS does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic             adj_pulse_w;
    logic             unused_adj_level;
    logic             step;
    count_op_e        op;
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    bcd_t             bcd;

    button_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_adjust (
        .clk        (clk),
        .clear      (clear),
        .raw        (adjust),
        .level      (unused_adj_level),
        .rise_pulse (adj_pulse_w)
    );

    // A tick and an adjust pulse on the same edge are one step, not two.
    assign step = tick | adj_pulse_w;

    always_comb begin
        op = OP_IDLE;
        if (load) begin
            op = OP_LOAD;
        end else if (keep) begin
            op = OP_KEEP;
        end else if (step) begin
            op = down ? OP_DOWN : OP_UP;
        end
    end

    // Only a tick-caused wrap reports carry/borrow, so adjusting one digit
    // never disturbs the next digit in the chain.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        case (op)
            OP_LOAD: begin
                count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
            end
            OP_UP: begin
                if (count_q == MAX_COUNT) begin
                    count_d = '0;
                    carry_d = tick;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            OP_DOWN: begin
                if (count_q == '0) begin
                    count_d  = MAX_COUNT;
                    borrow_d = tick;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // count never exceeds 99, so 7 bits carry the full value.
    assign bcd = to_bcd(7'(count_q));

    assign count     = count_q;
    assign carry     = carry_q;
    assign borrow    = borrow_q;
    assign adj_pulse = adj_pulse_w;
    assign tens      = bcd.tens;
    assign ones      = bcd.ones;

endmodule : modn_counter

// File: doc/modn_counter.md
Name: modn_counter

Overview:
Parametrised modulo-N time-digit counter; the generalised successor of the fixed 60-count digit counter used in the clock datapath.
- Counts up or down on a single-cycle tick strobe.
- Accepts a raw pushbutton adjust input, which it synchronises and debounces internally.
- Supports parallel load and produces registered carry/borrow pulses, so instances chain as seconds -> minutes -> hours.
- Provides BCD tens/ones outputs for the display driver.

Parameters:
MODULUS, 60, count range 0..MODULUS-1; legal range 2..100 (BCD limit).
WIDTH, 6, count width; MODULUS <= 2**WIDTH is required; elaboration error otherwise.
SYNC_STAGES, 2, flip-flop stages in the adjust synchroniser; minimum 2.
DEBOUNCE_CYCLES, 4, consecutive stable samples required before the debounced adjust level changes; minimum 1.

Ports:
clk  in  1  single system clock; all state is on its rising edge.
clear  in  1  reset, asynchronous and active-high.
tick  in  1  count-enable strobe, one clk cycle wide (from the prescaler or an upstream carry/borrow).
adjust  in  1  raw asynchronous pushbutton, active-high.
keep  in  1  hold; freezes count against tick and adjust.
down  in  1  direction: 0 = up, 1 = down.
load  in  1  synchronous parallel load.
load_value  in  WIDTH  value written on load.
count  out  WIDTH  current count.
carry  out  1  registered pulse: up-wrap caused by tick.
borrow  out  1  registered pulse: down-wrap caused by tick.
adj_pulse  out  1  debounced adjust rising-edge pulse, one cycle.
tens  out  4  BCD tens digit of count, combinational.
ones  out  4  BCD ones digit of count, combinational.

Behaviour:
- While clear is high, regardless of clk:
  - count = 0, carry = borrow = adj_pulse = 0.
  - All synchroniser and debounce state = 0; the debounced level reads as released.
- clear deassertion:
  - No spurious adj_pulse, even if adjust is already held high; a new debounced rise is required.
  - A mid-debounce clear discards that press.
- step = tick | adj_pulse. Tick and adj_pulse in the same cycle advance count by one step, not two.
- Per-edge priority:
  1. load: count = min(load_value, MODULUS-1). No carry or borrow is generated.
  2. keep: count holds. Tick and adj_pulse that cycle are dropped, not queued.
  3. step with down=0: count = (count == MODULUS-1) ? 0 : count+1.
  4. step with down=1: count = (count == 0) ? MODULUS-1 : count-1.
  5. Otherwise count holds.
- carry:
  - Goes high for exactly the one cycle after an edge where an up-wrap occurred and tick was high.
  - A wrap caused solely by adj_pulse produces no carry, so adjusting minutes never bumps hours.
  - carry is low whenever load or keep won priority.
- borrow: same rules as carry, for the down-wrap.
- Adjust conditioning:
  - SYNC_STAGES-deep synchroniser.
  - Stability counter resets on any change of the synchronised level.
  - The debounced level toggles after DEBOUNCE_CYCLES consecutive equal samples differing from it.
  - adj_pulse is the registered rising edge of the debounced level.
- Adjust latency: with adjust held steady high from the edge that first samples it (edge 0), adj_pulse is high during the cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge 6, and count updates at edge 7.
- Adjust glitches: any glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse. Holding adjust produces exactly one pulse; there is no auto-repeat.
- BCD outputs: tens = count/10, ones = count%10, both zero-extended.
- Arithmetic: all arithmetic is WIDTH bits. count never leaves 0..MODULUS-1.

Decomposition:
- Shared package clock_pkg holds:
  - constants SEC_MODULUS=60, MIN_MODULUS=60, HOUR_MODULUS=24;
  - DEFAULT_DEBOUNCE_CYCLES=4 and DEFAULT_SYNC_STAGES=2;
  - function to_bcd(count) -> {tens, ones}, shared with the display block.
- Sub-module button_conditioner(clk, clear, raw, level, rise_pulse), parametrised by SYNC_STAGES and DEBOUNCE_CYCLES. It is reused by the mode/set buttons.
- modn_counter holds only the counting FSM and the carry/borrow registers.

Test Plan:
1. MODULUS=60, up, tick every cycle from clear -> count 0..59 then 0; carry high exactly one cycle after the 59->0 edge; tens/ones = 5/9 at 59.
2. MODULUS=24, down=1, count=0, tick -> count 23, borrow pulses once; load_value=30 with load -> count 23, no carry/borrow.
3. Defaults: adjust high for 3 cycles then low -> no adj_pulse. Held 20 cycles -> exactly one adj_pulse, cycle after edge 6; count 0->1 at edge 7.
4. count=59, adj_pulse and tick in the same cycle -> count 0 (single step), carry=1. Repeat with adjust only -> count 0, carry=0.
5. keep=1 with ticks and an adjust press -> count frozen, carry=0. After keep drops, the press is not replayed.
6. Assert clear mid-debounce and while count=37, async relative to clk -> count 0 immediately. Release clear with adjust still held -> no adj_pulse until release and re-press.
